// File: rtl/instr_align_expand.sv
// instr_align_expand
//   Sits between instruction fetch and the decoder. It takes 4-byte-aligned
//   32-bit fetch words and turns them into a stream of whole instructions.
//   A 32-bit instruction may straddle two fetch words. RV32C halfwords are
//   expanded to their 32-bit equivalents, so the decoder only ever sees
//   32-bit raw instructions.
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   flush        : redirect; drops buffered halfwords and reloads the PC
//   flush_pc     : new PC on flush (bit1 set means start at the high halfword)
//   in_valid     : fetch word handshake (valid)
//   in_ready     : fetch word handshake (ready), depends on state only
//   in_data      : fetch word, little-endian halfwords
//   out_valid    : instruction handshake (valid)
//   out_ready    : instruction handshake (ready)
//   out_instr    : expanded 32-bit instruction (zero when not valid)
//   out_pc       : PC of the presented instruction
//   out_is_c     : the instruction came from a 16-bit encoding
//   out_illegal  : illegal or reserved compressed encoding; out_instr holds
//                  the raw halfword zero-extended
module instr_align_expand #(
  parameter int XLEN     = 32,
  parameter int EXPAND_C = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_is_c,
  output logic            out_illegal
);

  // Expand one RV32C halfword. Result is {illegal, instruction}.
  function automatic logic [32:0] f_expand(input logic [15:0] c);
    logic [31:0] ins;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rp_lo;   // rd'/rs2' from c[4:2]
    logic [4:0]  rp_hi;   // rd'/rs1' from c[9:7]
    logic [11:0] imm_i;
    logic [20:0] jimm;
    logic [12:0] bimm;
    ins   = 32'h0000_0000;
    ill   = 1'b0;
    rd    = c[11:7];
    rs2   = c[6:2];
    rp_lo = {2'b01, c[4:2]};
    rp_hi = {2'b01, c[9:7]};
    imm_i = {{6{c[12]}}, c[12], c[6:2]};
    jimm  = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    bimm  = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin  // C.ADDI4SPN
            ins = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rp_lo, 7'b0010011};
            ill = (c[12:5] == 8'h00);
          end
          3'b010: ins = {5'b00000, c[5], c[12:10], c[6], 2'b00, rp_hi, 3'b010, rp_lo, 7'b0000011};  // C.LW
          3'b110: ins = {5'b00000, c[5], c[12], rp_lo, rp_hi, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};  // C.SW
          default: ill = 1'b1;  // FP loads/stores and reserved
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: ins = {imm_i, rd, 3'b000, rd, 7'b0010011};  // C.NOP / C.ADDI
          3'b001: ins = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'b1101111};  // C.JAL
          3'b010: ins = {imm_i, 5'd0, 3'b000, rd, 7'b0010011};  // C.LI
          3'b011: begin
            if (rd == 5'd2) begin  // C.ADDI16SP
              ins = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
            end else begin  // C.LUI
              ins = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
            end
            ill = ({c[12], c[6:2]} == 6'd0);
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin  // C.SRLI; shamt[5] only exists on RV64
                ins = {7'b0000000, c[6:2], rp_hi, 3'b101, rp_hi, 7'b0010011};
                ill = c[12];
              end
              2'b01: begin  // C.SRAI
                ins = {7'b0100000, c[6:2], rp_hi, 3'b101, rp_hi, 7'b0010011};
                ill = c[12];
              end
              2'b10: ins = {imm_i, rp_hi, 3'b111, rp_hi, 7'b0010011};  // C.ANDI
              default: begin
                if (c[12]) begin
                  ill = 1'b1;  // C.SUBW/C.ADDW and reserved
                end else begin
                  case (c[6:5])
                    2'b00:   ins = {7'b0100000, rp_lo, rp_hi, 3'b000, rp_hi, 7'b0110011};
                    2'b01:   ins = {7'b0000000, rp_lo, rp_hi, 3'b100, rp_hi, 7'b0110011};
                    2'b10:   ins = {7'b0000000, rp_lo, rp_hi, 3'b110, rp_hi, 7'b0110011};
                    default: ins = {7'b0000000, rp_lo, rp_hi, 3'b111, rp_hi, 7'b0110011};
                  endcase
                end
              end
            endcase
          end
          3'b101: ins = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'b1101111};  // C.J
          3'b110: ins = {bimm[12], bimm[10:5], 5'd0, rp_hi, 3'b000, bimm[4:1], bimm[11], 7'b1100011};
          3'b111: ins = {bimm[12], bimm[10:5], 5'd0, rp_hi, 3'b001, bimm[4:1], bimm[11], 7'b1100011};
          default: ill = 1'b1;
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin  // C.SLLI
            ins = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011};
            ill = c[12];
          end
          3'b010: begin  // C.LWSP
            ins = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
            ill = (rd == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin  // C.JR
                ins = {12'h000, rd, 3'b000, 5'd0, 7'b1100111};
                ill = (rd == 5'd0);
              end else begin  // C.MV
                ins = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};
              end
            end else begin
              if (rs2 != 5'd0) begin  // C.ADD
                ins = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};
              end else if (rd == 5'd0) begin  // C.EBREAK
                ins = 32'h0010_0073;
              end else begin  // C.JALR
                ins = {12'h000, rd, 3'b000, 5'd1, 7'b1100111};
              end
            end
          end
          3'b110: ins = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};  // C.SWSP
          default: ill = 1'b1;  // FP stack loads/stores
        endcase
      end
      default: ill = 1'b1;  // 2'b11 is never routed here
    endcase
    return {ill, ins};
  endfunction

  logic [15:0]     r_hb [3];
  logic [1:0]      r_cnt;
  logic [XLEN-1:0] r_pc;
  logic            r_skip;

  logic [15:0]     w_hb_nxt [3];
  logic [1:0]      w_cnt_nxt;
  logic [1:0]      w_cnt_rem;
  logic [1:0]      w_cons;
  logic [1:0]      w_app;
  logic            w_acc;
  logic            w_is32;
  logic            w_valid;
  logic [32:0]     w_exp;
  logic            w_ill_c;
  logic [31:0]     w_instr_c;

  assign in_ready = (r_cnt <= 2'd1);
  assign w_acc    = in_valid & in_ready;
  assign w_is32   = (r_hb[0][1:0] == 2'b11);
  assign w_valid  = w_is32 ? (r_cnt >= 2'd2) : (r_cnt >= 2'd1);
  assign w_exp    = f_expand(r_hb[0]);

  // Compressed path: select expansion or raw halfword on illegal encodings
  always_comb begin
    if (EXPAND_C != 0) begin
      w_ill_c = w_exp[32];
    end else begin
      w_ill_c = 1'b1;
    end
    if (w_ill_c) begin
      w_instr_c = {16'h0000, r_hb[0]};
    end else begin
      w_instr_c = w_exp[31:0];
    end
  end

  // Output decode; everything except the PC reads as zero when nothing is valid
  always_comb begin
    out_valid   = w_valid;
    out_pc      = r_pc;
    out_instr   = 32'h0000_0000;
    out_is_c    = 1'b0;
    out_illegal = 1'b0;
    if (!w_valid) begin
      out_instr = 32'h0000_0000;
    end else if (w_is32) begin
      out_instr = {r_hb[1], r_hb[0]};
    end else begin
      out_instr   = w_instr_c;
      out_is_c    = 1'b1;
      out_illegal = w_ill_c;
    end
  end

  // Next buffer: shift out consumed halfwords, then append accepted ones
  always_comb begin
    if (w_valid && out_ready) begin
      w_cons = w_is32 ? 2'd2 : 2'd1;
    end else begin
      w_cons = 2'd0;
    end
    if (w_acc) begin
      w_app = r_skip ? 2'd1 : 2'd2;
    end else begin
      w_app = 2'd0;
    end
    w_cnt_rem = r_cnt - w_cons;
    w_cnt_nxt = w_cnt_rem + w_app;
    case (w_cons)
      2'd1: begin
        w_hb_nxt[0] = r_hb[1];
        w_hb_nxt[1] = r_hb[2];
        w_hb_nxt[2] = 16'h0000;
      end
      2'd2: begin
        w_hb_nxt[0] = r_hb[2];
        w_hb_nxt[1] = 16'h0000;
        w_hb_nxt[2] = 16'h0000;
      end
      default: begin
        w_hb_nxt[0] = r_hb[0];
        w_hb_nxt[1] = r_hb[1];
        w_hb_nxt[2] = r_hb[2];
      end
    endcase
    // Accept only happens with cnt <= 1, so at most one halfword remains
    if (w_acc) begin
      case (w_cnt_rem)
        2'd0: begin
          if (r_skip) begin
            w_hb_nxt[0] = in_data[31:16];
          end else begin
            w_hb_nxt[0] = in_data[15:0];
            w_hb_nxt[1] = in_data[31:16];
          end
        end
        2'd1: begin
          if (r_skip) begin
            w_hb_nxt[1] = in_data[31:16];
          end else begin
            w_hb_nxt[1] = in_data[15:0];
            w_hb_nxt[2] = in_data[31:16];
          end
        end
        default: begin
          w_hb_nxt[2] = w_hb_nxt[2];
        end
      endcase
    end else begin
      w_hb_nxt[2] = w_hb_nxt[2];
    end
  end

  // State registers; flush overrides both accept and consume
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hb[0] <= 16'h0000;
      r_hb[1] <= 16'h0000;
      r_hb[2] <= 16'h0000;
      r_cnt   <= 2'd0;
      r_pc    <= '0;
      r_skip  <= 1'b0;
    end else if (flush) begin
      r_cnt   <= 2'd0;
      r_pc    <= flush_pc;
      r_skip  <= flush_pc[1];
    end else begin
      r_hb[0] <= w_hb_nxt[0];
      r_hb[1] <= w_hb_nxt[1];
      r_hb[2] <= w_hb_nxt[2];
      r_cnt   <= w_cnt_nxt;
      // w_cons << 1 gives the PC step of 2 or 4 bytes; wraps naturally
      r_pc    <= r_pc + {{(XLEN-3){1'b0}}, w_cons, 1'b0};
      if (w_acc) begin
        r_skip <= 1'b0;
      end else begin
        r_skip <= r_skip;
      end
    end
  end

endmodule

// File: tb/tb_instr_align_expand.sv
module tb_instr_align_expand;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_c;
  logic        out_illegal;

  int n_pass  = 0;
  int n_total = 0;

  instr_align_expand #(.XLEN(32), .EXPAND_C(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_is_c(out_is_c), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0] hw;
    logic [31:0] ins;
    logic        ill;
  } vec_t;

  vec_t vt [23];

  logic [31:0] s_w [8];
  logic [31:0] e_i [8];
  logic [31:0] e_p [8];
  logic        e_c [8];
  logic        e_l [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic set_exp(input int k, input logic [31:0] ins, input logic [31:0] pc,
                         input logic c, input logic l);
    e_i[k] = ins; e_p[k] = pc; e_c[k] = c; e_l[k] = l;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush = 1'b1; flush_pc = pc; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Offer words s_w[first..nw-1] with out_ready=1 and check nexp outputs in order
  task automatic run_stream(input int first, input int nw, input int nexp, input string tag);
    int  idx;
    int  got;
    logic acc;
    idx = first; got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < nexp; cyc++) begin
      in_valid = (idx < nw);
      in_data  = (idx < nw) ? s_w[idx] : 32'h0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("%s_instr%0d", tag, got), out_instr, e_i[got]);
        chk($sformatf("%s_pc%0d", tag, got), out_pc, e_p[got]);
        chk1($sformatf("%s_isc%0d", tag, got), out_is_c, e_c[got]);
        chk1($sformatf("%s_ill%0d", tag, got), out_illegal, e_l[got]);
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk($sformatf("%s_count", tag), 32'(got), 32'(nexp));
    chk($sformatf("%s_words", tag), 32'(idx), 32'(nw));
    @(negedge clk);
    chk1($sformatf("%s_drained", tag), out_valid, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] held;
    vt[0]  = '{16'h0040, 32'h00410413, 1'b0};  // C.ADDI4SPN x8,4
    vt[1]  = '{16'h4044, 32'h00442483, 1'b0};  // C.LW x9,4(x8)
    vt[2]  = '{16'hC044, 32'h00942223, 1'b0};  // C.SW x9,4(x8)
    vt[3]  = '{16'h557D, 32'hFFF00513, 1'b0};  // C.LI x10,-1
    vt[4]  = '{16'h6505, 32'h00001537, 1'b0};  // C.LUI x10,1
    vt[5]  = '{16'h6141, 32'h01010113, 1'b0};  // C.ADDI16SP 16
    vt[6]  = '{16'h3FFD, 32'hFFFFF0EF, 1'b0};  // C.JAL -2
    vt[7]  = '{16'hA001, 32'h0000006F, 1'b0};  // C.J 0
    vt[8]  = '{16'hC401, 32'h00040463, 1'b0};  // C.BEQZ x8,8
    vt[9]  = '{16'h840D, 32'h40345413, 1'b0};  // C.SRAI x8,3
    vt[10] = '{16'h8C65, 32'h00947433, 1'b0};  // C.AND x8,x9
    vt[11] = '{16'h050A, 32'h00251513, 1'b0};  // C.SLLI x10,2
    vt[12] = '{16'h4512, 32'h00412503, 1'b0};  // C.LWSP x10,4
    vt[13] = '{16'hC22A, 32'h00A12223, 1'b0};  // C.SWSP x10,4
    vt[14] = '{16'h8082, 32'h00008067, 1'b0};  // C.JR x1
    vt[15] = '{16'h9002, 32'h00100073, 1'b0};  // C.EBREAK
    vt[16] = '{16'h9082, 32'h000080E7, 1'b0};  // C.JALR x1
    vt[17] = '{16'h952E, 32'h00B50533, 1'b0};  // C.ADD x10,x11
    vt[18] = '{16'h0000, 32'h00000000, 1'b1};  // all-zero halfword
    vt[19] = '{16'h4002, 32'h00004002, 1'b1};  // C.LWSP rd=0
    vt[20] = '{16'h8002, 32'h00008002, 1'b1};  // C.JR rs1=0
    vt[21] = '{16'h6501, 32'h00006501, 1'b1};  // C.LUI imm=0
    vt[22] = '{16'h2000, 32'h00002000, 1'b1};  // C.FLD

    reset = 1'b1; flush = 1'b0; flush_pc = 32'h0; in_valid = 1'b0;
    in_data = 32'h0; out_ready = 1'b0;
    #12;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk1("rst_is_c", out_is_c, 1'b0);
    chk1("rst_illegal", out_illegal, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table: compressed halfword low, C.NOP high
    for (int i = 0; i < 23; i++) begin
      base = 32'h1000 + 32'(i) * 32'h10;
      do_flush(base);
      in_valid = 1'b1; in_data = {16'h0001, vt[i].hw};
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_instr", i), out_instr, vt[i].ins);
      chk($sformatf("vec%0d_pc", i), out_pc, base);
      chk1($sformatf("vec%0d_ill", i), out_illegal, vt[i].ill);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_next_instr", i), out_instr, 32'h00000013);
      chk($sformatf("vec%0d_next_pc", i), out_pc, base + 32'd2);
    end

    // Straddling 32-bit instruction
    do_flush(32'h0);
    s_w[0] = 32'h80930085; s_w[1] = 32'h852E0010;
    set_exp(0, 32'h00108093, 32'h0, 1'b1, 1'b0);
    set_exp(1, 32'h00108093, 32'h2, 1'b0, 1'b0);
    set_exp(2, 32'h00B00533, 32'h6, 1'b1, 1'b0);
    run_stream(0, 2, 3, "straddle");

    // Flush to an odd halfword: low half of the next word is skipped
    do_flush(32'h102);
    s_w[0] = 32'h852E0085;
    set_exp(0, 32'h00B00533, 32'h102, 1'b1, 1'b0);
    run_stream(0, 1, 1, "skip");

    // Illegal halfwords still advance the PC by 2
    do_flush(32'h2000);
    s_w[0] = 32'h40020000;
    set_exp(0, 32'h00000000, 32'h2000, 1'b1, 1'b1);
    set_exp(1, 32'h00004002, 32'h2002, 1'b1, 1'b1);
    run_stream(0, 1, 2, "illegal");

    // Backpressure: eight C.LI xj+1,j halfwords in four words
    do_flush(32'h0);
    for (int j = 0; j < 4; j++) begin
      s_w[j] = {3'b010, 1'b0, 5'(2*j+2), 5'(2*j+1), 2'b01,
                3'b010, 1'b0, 5'(2*j+1), 5'(2*j), 2'b01};
    end
    for (int j = 0; j < 8; j++) begin
      set_exp(j, {7'b0, 5'(j), 5'd0, 3'b000, 5'(j+1), 7'b0010011}, 32'(2*j), 1'b1, 1'b0);
    end
    in_valid = 1'b1; in_data = s_w[0];
    @(posedge clk); #1;
    held = e_i[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("bp_in_ready%0d", k), in_ready, 1'b0);
      chk1($sformatf("bp_valid%0d", k), out_valid, 1'b1);
      chk($sformatf("bp_hold_instr%0d", k), out_instr, held);
      chk($sformatf("bp_hold_pc%0d", k), out_pc, 32'h0);
      @(posedge clk); #1;
    end
    run_stream(1, 4, 8, "bp");

    // Flush in the same cycle as accept and consume
    do_flush(32'h2);
    in_valid = 1'b1; in_data = 32'h00851234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("fc_pre_valid", out_valid, 1'b1);
    chk1("fc_pre_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = 32'h852E0085; out_ready = 1'b1;
    flush = 1'b1; flush_pc = 32'h200;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk1("fc_valid", out_valid, 1'b0);
    chk1("fc_in_ready", in_ready, 1'b1);
    chk("fc_pc", out_pc, 32'h200);
    @(posedge clk); #1;
    s_w[0] = 32'h952E0085;
    set_exp(0, 32'h00108093, 32'h200, 1'b1, 1'b0);
    set_exp(1, 32'h00B50533, 32'h202, 1'b1, 1'b0);
    run_stream(0, 1, 2, "fc");

    // PC wraps past the top of the address space
    do_flush(32'hFFFFFFFE);
    s_w[0] = 32'h00850001; s_w[1] = 32'h00010085;
    set_exp(0, 32'h00108093, 32'hFFFFFFFE, 1'b1, 1'b0);
    set_exp(1, 32'h00108093, 32'h0, 1'b1, 1'b0);
    set_exp(2, 32'h00000013, 32'h2, 1'b1, 1'b0);
    run_stream(0, 2, 3, "wrap");

    // Asynchronous reset with two halfwords buffered
    do_flush(32'h300);
    in_valid = 1'b1; in_data = 32'h00850085;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("mr_pre_valid", out_valid, 1'b1);
    chk1("mr_pre_ready", in_ready, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk1("mr_valid", out_valid, 1'b0);
    chk1("mr_in_ready", in_ready, 1'b1);
    chk("mr_pc", out_pc, 32'h0);
    chk("mr_instr", out_instr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("mr_after_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
